// File: rtl/pet_feeder_pkg.sv
// Shared definitions for the pet feeder and its keypad front end:
// option codes, key classes and the scanner state encoding.
package pet_feeder_pkg;

    // Option codes carried on keyboard_option
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] POUR_FOOD = 3'd1;
    localparam logic [2:0] STOP_FOOD = 3'd2;
    localparam logic [2:0] INTERVAL  = 3'd3;
    localparam logic [2:0] RESET     = 3'd4;

    typedef enum logic [1:0] {
        KEY_NONE   = 2'd0,
        KEY_DIGIT  = 2'd1,
        KEY_OPTION = 2'd2
    } key_class_t;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        REPORT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } scan_state_t;

    // True when exactly one of the four bits is set
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Index of the set bit of a one-hot nibble (lowest set bit otherwise)
    function automatic logic [1:0] onehot_index4(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[3]) idx = 2'd3;
        if (v[2]) idx = 2'd2;
        if (v[1]) idx = 2'd1;
        if (v[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Combinational map from (row, column) of a 4x4 keypad to a key class and
// value. Digit keys give 0-9, the letter column and '*' give option codes,
// '#' gives KEY_NONE.
module keypad_decoder
    import pet_feeder_pkg::*;
(
    input  logic [1:0] row,
    input  logic [1:0] col,
    output key_class_t key_class,
    output logic [3:0] value
);

    // Decode the key position
    always_comb begin
        key_class = KEY_DIGIT;
        value     = 4'd0;
        if (col == 2'd3) begin
            key_class = KEY_OPTION;
            case (row)
                2'd0:    value = {1'b0, POUR_FOOD};
                2'd1:    value = {1'b0, STOP_FOOD};
                2'd2:    value = {1'b0, INTERVAL};
                default: value = {1'b0, RESET};
            endcase
        end else if (row == 2'd3) begin
            case (col)
                2'd0: begin
                    key_class = KEY_OPTION;
                    value     = {1'b0, IDLE};
                end
                2'd1: begin
                    key_class = KEY_DIGIT;
                    value     = 4'd0;
                end
                default: begin
                    key_class = KEY_NONE;
                    value     = 4'd0;
                end
            endcase
        end else begin
            // Rows 0-2, columns 0-2 hold digits 1-9 in reading order
            value = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives one column at a time, synchronizes and
// debounces the row returns, and reports each accepted key once as a
// digit or option update with a one-cycle enable.
module keypad_scanner
    import pet_feeder_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] kp_rows,
    output logic [3:0] kp_cols,
    output logic [2:0] keyboard_option,
    output logic       option_enable,
    output logic [3:0] keyboard_digit,
    output logic       digit_enable,
    output logic       key_pressed
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    rows_m, rows_s;
    scan_state_t   state, state_next;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cnt;
    logic [1:0]    row_idx, col_idx;
    key_class_t    key_class;
    logic [3:0]    key_value;

    logic dwell_done, row_single, row_match, no_rows, cnt_done;
    logic dwell_clr, dwell_inc, rotate, latch, cnt_clr, cnt_inc;
    logic do_report, do_release;

    assign dwell_done = (dwell == DWELL_LAST);
    assign row_single = is_onehot4(rows_s);
    assign row_match  = (rows_s == (4'b0001 << row_idx));
    assign no_rows    = (rows_s == 4'd0);
    assign cnt_done   = (cnt == CNT_LAST);

    keypad_decoder u_decoder (
        .row       (row_idx),
        .col       (col_idx),
        .key_class (key_class),
        .value     (key_value)
    );

    // Two-flop synchronizer for the asynchronous row returns
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rows_m <= 4'd0;
            rows_s <= 4'd0;
        end else begin
            rows_m <= kp_rows;
            rows_s <= rows_m;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= SCAN;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            SCAN:         if (dwell_done && row_single) state_next = DEBOUNCE;
            DEBOUNCE:     if (!row_match)               state_next = SCAN;
                          else if (cnt_done)            state_next = REPORT;
            REPORT:                                     state_next = WAIT_RELEASE;
            WAIT_RELEASE: if (no_rows && cnt_done)      state_next = SCAN;
            default:                                    state_next = SCAN;
        endcase
    end

    // Per-state actions on counters, column drive and outputs
    always_comb begin
        dwell_clr  = 1'b0;
        dwell_inc  = 1'b0;
        rotate     = 1'b0;
        latch      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        do_report  = 1'b0;
        do_release = 1'b0;
        case (state)
            SCAN: begin
                if (dwell_done) begin
                    dwell_clr = 1'b1;
                    if (row_single) begin
                        latch   = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        rotate = 1'b1;
                    end
                end else begin
                    dwell_inc = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_match) begin
                    dwell_clr = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (cnt_done) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            REPORT: begin
                do_report = 1'b1;
                cnt_clr   = 1'b1;
            end
            WAIT_RELEASE: begin
                if (!no_rows) begin
                    cnt_clr = 1'b1;
                end else if (cnt_done) begin
                    do_release = 1'b1;
                    rotate     = 1'b1;
                    dwell_clr  = 1'b1;
                    cnt_clr    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Dwell and debounce counters, column rotation, latched key position
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dwell   <= '0;
            cnt     <= '0;
            kp_cols <= 4'b0001;
            row_idx <= 2'd0;
            col_idx <= 2'd0;
        end else begin
            if (dwell_clr)      dwell <= '0;
            else if (dwell_inc) dwell <= dwell + DW'(1);
            if (cnt_clr)        cnt <= '0;
            else if (cnt_inc)   cnt <= cnt + CW'(1);
            if (rotate)         kp_cols <= {kp_cols[2:0], kp_cols[3]};
            if (latch) begin
                row_idx <= onehot_index4(rows_s);
                col_idx <= onehot_index4(kp_cols);
            end
        end
    end

    // Registered keyboard outputs and one-cycle enables
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            keyboard_option <= IDLE;
            keyboard_digit  <= 4'd0;
            option_enable   <= 1'b0;
            digit_enable    <= 1'b0;
            key_pressed     <= 1'b0;
        end else begin
            option_enable <= 1'b0;
            digit_enable  <= 1'b0;
            if (do_report) begin
                key_pressed <= 1'b1;
                if (key_class == KEY_DIGIT) begin
                    keyboard_digit <= key_value;
                    digit_enable   <= 1'b1;
                end else if (key_class == KEY_OPTION) begin
                    keyboard_option <= key_value[2:0];
                    option_enable   <= 1'b1;
                end
            end else if (do_release) begin
                key_pressed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad matrix.
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] kp_rows = 4'd0;
    logic [3:0] kp_cols;
    logic [2:0] keyboard_option;
    logic       option_enable;
    logic [3:0] keyboard_digit;
    logic       digit_enable;
    logic       key_pressed;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .kp_rows         (kp_rows),
        .kp_cols         (kp_cols),
        .keyboard_option (keyboard_option),
        .option_enable   (option_enable),
        .keyboard_digit  (keyboard_digit),
        .digit_enable    (digit_enable),
        .key_pressed     (key_pressed)
    );

    always #5 clock = ~clock;

    // Closed switches: mat[col][row]
    logic [3:0] mat [4];
    int n_cmp = 0;
    int n_err = 0;
    int n_dig = 0;
    int n_opt = 0;
    int n_both = 0;
    int seen_kp = 0;
    logic [3:0] last_dig = 4'd0;
    logic [2:0] last_opt = 3'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_rows();
        logic [3:0] r;
        r = 4'd0;
        for (int c = 0; c < 4; c++)
            if (kp_cols[c]) r = r | mat[c];
        return r;
    endfunction

    task automatic apply();
        kp_rows = col_rows();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        kp_rows = col_rows();
        if (digit_enable) begin n_dig++; last_dig = keyboard_digit; end
        if (option_enable) begin n_opt++; last_opt = keyboard_option; end
        if (digit_enable && option_enable) n_both++;
        if (key_pressed) seen_kp++;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        n_dig = 0; n_opt = 0; seen_kp = 0;
    endtask

    task automatic release_all();
        for (int c = 0; c < 4; c++) mat[c] = 4'd0;
        apply();
    endtask

    initial begin
        logic [3:0] exp_cols;
        for (int c = 0; c < 4; c++) mat[c] = 4'd0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_cols", kp_cols, 4'b0001);
        check("rst_opt", keyboard_option, 3'd0);
        check("rst_dig", keyboard_digit, 4'd0);
        check("rst_oen", option_enable, 1'b0);
        check("rst_den", digit_enable, 1'b0);
        check("rst_kp", key_pressed, 1'b0);

        // Column rotation, 4 cycles per column
        reset = 1'b0;
        check("cols_0", kp_cols, 4'b0001);
        for (int k = 1; k <= 19; k++) begin
            tick();
            exp_cols = 4'b0001 << ((k / 4) % 4);
            check($sformatf("cols_%0d", k), kp_cols, exp_cols);
        end

        // Digit "5": row 1, column 1
        clear_counts();
        mat[1] = 4'b0010; apply();
        hold(40);
        check("d5_cnt", n_dig, 1);
        check("d5_val", last_dig, 4'd5);
        check("d5_out", keyboard_digit, 4'd5);
        check("d5_opt", n_opt, 0);
        check("d5_kp", key_pressed, 1'b1);
        release_all();
        hold(9);
        check("d5_kp_held", key_pressed, 1'b1);
        tick();
        check("d5_kp_rel", key_pressed, 1'b0);
        check("d5_next_col", kp_cols, 4'b0100);
        hold(2);

        // Option "C" then "B"
        clear_counts();
        mat[3] = 4'b0100; apply();
        hold(40);
        check("oc_cnt", n_opt, 1);
        check("oc_val", last_opt, 3'd3);
        check("oc_dig", n_dig, 0);
        release_all();
        hold(12);
        check("oc_hold", keyboard_option, 3'd3);
        check("oc_kp", key_pressed, 1'b0);
        clear_counts();
        mat[3] = 4'b0010; apply();
        hold(40);
        check("ob_cnt", n_opt, 1);
        check("ob_val", keyboard_option, 3'd2);
        check("ob_dig_keep", keyboard_digit, 4'd5);
        release_all();
        hold(12);

        // Bouncing "1" then stable "1"
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            mat[0] = mat[0] ^ 4'b0001; apply();
            hold(3);
        end
        release_all();
        hold(12);
        check("bnc_cnt", n_dig, 0);
        check("bnc_kp", seen_kp, 0);
        mat[0] = 4'b0001; apply();
        hold(40);
        check("b1_cnt", n_dig, 1);
        check("b1_val", keyboard_digit, 4'd1);
        release_all();
        hold(12);

        // Ghost chord in column 2
        clear_counts();
        mat[2] = 4'b0011; apply();
        hold(40);
        check("ghost_cnt", n_dig + n_opt, 0);
        check("ghost_kp", seen_kp, 0);
        release_all();
        hold(4);

        // Held "7", then "9" while "7" still held
        clear_counts();
        mat[0] = 4'b0100; apply();
        hold(200);
        check("h7_cnt", n_dig, 1);
        check("h7_val", keyboard_digit, 4'd7);
        mat[2] = 4'b0100; apply();
        hold(40);
        check("h9_ign", n_dig, 1);
        check("h9_val", keyboard_digit, 4'd7);
        check("h9_kp", key_pressed, 1'b1);
        release_all();
        hold(12);

        // Sequence "6", "4", "#"
        clear_counts();
        mat[2] = 4'b0010; apply();
        hold(40);
        check("s6_val", keyboard_digit, 4'd6);
        check("s6_cnt", n_dig, 1);
        release_all();
        hold(12);
        mat[0] = 4'b0010; apply();
        hold(40);
        check("s4_val", keyboard_digit, 4'd4);
        check("s4_cnt", n_dig, 2);
        release_all();
        hold(12);
        mat[2] = 4'b1000; apply();
        hold(40);
        check("sh_kp", key_pressed, 1'b1);
        check("sh_cnt", n_dig + n_opt, 2);
        check("sh_dig", keyboard_digit, 4'd4);
        release_all();
        hold(12);
        check("sh_rel", key_pressed, 1'b0);
        check("excl", n_both, 0);

        // Reset in the middle of an option pulse ("D")
        mat[3] = 4'b1000; apply();
        for (int i = 0; i < 60 && !option_enable; i++) tick();
        check("d_pulse", option_enable, 1'b1);
        check("d_val", keyboard_option, 3'd4);
        reset = 1'b1;
        #1;
        check("mid_oen", option_enable, 1'b0);
        check("mid_opt", keyboard_option, 3'd0);
        check("mid_dig", keyboard_digit, 4'd0);
        check("mid_kp", key_pressed, 1'b0);
        check("mid_cols", kp_cols, 4'b0001);
        release_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Producer side of the feeder's keyboard interface.
- Scans a 4x4 matrix keypad, synchronizes and debounces the row returns, and decodes the pressed key.
- Emits the keyboard_option/option_enable and keyboard_digit/digit_enable pairs consumed by pet_feeder.
- Instantiated beside pet_feeder in the board top; its outputs connect 1:1 to pet_feeder's keyboard inputs.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven before the scan advances; must be >= 4.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a press or a release; must be >= 1.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- kp_rows  input  4  raw row returns; bit r high means a key in row r of the driven column is closed; asynchronous to clock.
- kp_cols  output  4  one-hot column drive, active-high.
- keyboard_option  output  3  last accepted option code; held between presses.
- option_enable  output  1  one-cycle pulse when keyboard_option is updated.
- keyboard_digit  output  4  last accepted digit 0-9; held between presses.
- digit_enable  output  1  one-cycle pulse when keyboard_digit is updated.
- key_pressed  output  1  high from press acceptance until release is accepted.

Behaviour:
- Reset values (applied immediately when reset is asserted):
  - kp_cols=4'b0001, keyboard_option=IDLE (3'b000), keyboard_digit=0.
  - option_enable=0, digit_enable=0, key_pressed=0.
  - state=SCAN, all counters cleared, synchronizer flops cleared.
  - A reset mid-pulse cuts the pulse.
- Row synchronization: kp_rows passes through a 2-flop synchronizer (rows_s). All decisions use rows_s only.
- Keypad map (row,col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Key classes:
  - Digit keys produce their value.
  - A=POUR_FOOD(1), B=STOP_FOOD(2), C=INTERVAL(3), D=RESET(4), *=IDLE(0).
  - # is accepted and debounced but produces no output.
- State machine (SCAN, DEBOUNCE, REPORT, WAIT_RELEASE):
  - SCAN:
    - A dwell counter counts 0..SCAN_DIV-1.
    - On the last dwell cycle rows_s is sampled.
    - If exactly one bit of rows_s is set: latch row and column, go to DEBOUNCE, and keep kp_cols unchanged.
    - Otherwise (zero bits, or two or more bits = ghost/chord): rotate kp_cols left (0b1000 wraps to 0b0001) and restart the dwell.
  - DEBOUNCE:
    - Count cycles while rows_s equals the latched one-hot row.
    - Any mismatch returns to SCAN at the same column with the dwell restarted. No output is produced.
    - When the count reaches DEBOUNCE_CYCLES, go to REPORT.
  - REPORT (exactly 1 cycle):
    - Set key_pressed.
    - Digit key: register keyboard_digit=value and digit_enable=1 on the next edge.
    - Option key: register keyboard_option=code and option_enable=1 on the next edge.
    - Go to WAIT_RELEASE.
  - WAIT_RELEASE:
    - Column is held.
    - Count consecutive cycles with rows_s==0; any nonzero row clears the count.
    - Other keys pressed meanwhile are ignored.
    - At DEBOUNCE_CYCLES: clear key_pressed, go to SCAN, and advance to the next column.
- Pulse rules:
  - Enables are registered, high for exactly one cycle, coincident with the first cycle of the new data value.
  - digit_enable and option_enable are never high together.
  - The unchanged data output keeps its value.
- Latency: from kp_rows going stable while its column is driven, the enable rises within 2 (sync) + SCAN_DIV + DEBOUNCE_CYCLES + 2 cycles.
- Repeated identical keys each produce a pulse, provided a release was accepted between them. Holding a key produces no auto-repeat.
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_CYCLES+1). No wrap is possible within a state.

Decomposition:
- Shared package pet_feeder_pkg holds:
  - option codes IDLE/POUR_FOOD/STOP_FOOD/INTERVAL/RESET (3-bit);
  - key-class encoding (KEY_DIGIT, KEY_OPTION, KEY_NONE);
  - scanner state encoding.
- pet_feeder uses the same option codes from the package.
- One sub-module, keypad_decoder: purely combinational (row index, column index) -> {key class, 4-bit value}. The FSM, counters and synchronizer stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- Reset: assert reset mid-scan -> kp_cols=0001 and all outputs at reset values immediately. After release, kp_cols sequence is 0001,0010,0100,1000,0001 with each value held 4 cycles.
- Digit press: hold row1 high only while kp_cols=0010 ("5"), stable for 40 cycles -> one digit_enable pulse with keyboard_digit=5, option_enable stays 0, key_pressed=1. Release for >=8 cycles -> key_pressed=0 and scanning resumes at 0100.
- Option press: row2/col3 ("C") -> one option_enable pulse with keyboard_option=3, which holds 3 afterwards. Then "B" -> keyboard_option=2.
- Bounce: toggle row0/col0 every 3 cycles for 30 cycles, then release -> no pulse, key_pressed never 1. Then hold stable -> exactly one pulse, digit=1.
- Ghost and held key: two rows high in one column -> scan keeps rotating, no pulse. Hold "7" for 200 cycles -> exactly one digit_enable. Press "9" while "7" is held -> ignored.
- Sequence "6","4","#", each followed by a release -> digit_enable pulses with 6 then 4. "#" gives no pulse but key_pressed toggles.
